// File: rtl/gray_sel_seq_pkg.sv
// Shared types and helpers for the Gray-coded select sequencer.
`ifndef GRAY_SEL_SEQ_PKG_SV
`define GRAY_SEL_SEQ_PKG_SV

// Elaboration-time guard: the key width must hold every index 1..NR,
// and at least one selectable entry must exist.
`define GRAY_SEL_CHECK_PARAMS(NR_, KW_) \
  if ((NR_) < 1 || (1 << (KW_)) <= (NR_)) begin : g_param_err \
    $error("gray_sel_seq: parameters need NR >= 1 and 2**KW > NR"); \
  end

package gray_sel_seq_pkg;

  // Widest select word the helper function handles.
  localparam int GW = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

`endif

// File: rtl/gray_sel_seq_idx_step.sv
// Combinational next-index for one handshake step, with wrap flag.
module gray_idx_step #(
  parameter int NR = 2,
  parameter int KW = 2
) (
  input  logic [KW-1:0] idx_i,
  input  logic          dir_i,
  output logic [KW-1:0] nxt_o,
  output logic          wrap_o
);

  // Step up or down through 1..NR, wrapping at either end.
  always_comb begin
    nxt_o  = idx_i;
    wrap_o = 1'b0;
    if (dir_i) begin
      if (idx_i == KW'(1)) begin
        nxt_o  = KW'(NR);
        wrap_o = 1'b1;
      end else begin
        nxt_o = idx_i - KW'(1);
      end
    end else begin
      if (idx_i == KW'(NR)) begin
        nxt_o  = KW'(1);
        wrap_o = 1'b1;
      end else begin
        nxt_o = idx_i + KW'(1);
      end
    end
  end

endmodule

// File: rtl/gray_sel_seq.sv
// Gray-keyed select sequencer: walks indices 1..NR under a valid/ready
// handshake and presents the registered Gray key to the downstream mux.
//
//   state | meaning
//   ------+-----------------------------------------------
//   IDLE  | select held, out_valid=0, steps ignored
//   RUN   | out_valid=1, each accepted select advances idx
module gray_sel_seq
  import gray_sel_seq_pkg::*;
#(
  parameter int NR = 2,
  parameter int KW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic          single,
  input  logic          dir,
  input  logic          load,
  input  logic [KW-1:0] load_idx,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [KW-1:0] sel_gray,
  output logic [KW-1:0] sel_idx,
  output logic          wrap,
  output logic          load_err
);

  `GRAY_SEL_CHECK_PARAMS(NR, KW)

  state_e        state_q, state_d;
  logic [KW-1:0] idx_q, idx_d;
  logic [KW-1:0] gray_q, gray_d;
  logic          wrap_q, wrap_d;
  logic          err_q, err_d;

  logic [KW-1:0] step_nxt;
  logic          step_wrap;
  logic          step;
  logic          load_ok;

  gray_idx_step #(.NR(NR), .KW(KW)) u_step (
    .idx_i  (idx_q),
    .dir_i  (dir),
    .nxt_o  (step_nxt),
    .wrap_o (step_wrap)
  );

  assign step    = (state_q == RUN) & out_ready;
  assign load_ok = load & (load_idx != '0) & (load_idx <= KW'(NR));
  assign gray_d  = KW'(bin2gray(GW'(idx_d)));

  // Next index and pulses: a valid load overrides a same-cycle step.
  always_comb begin
    idx_d  = idx_q;
    wrap_d = 1'b0;
    err_d  = load & ~load_ok;
    if (load_ok) begin
      idx_d = load_idx;
    end else if (step) begin
      idx_d  = step_nxt;
      wrap_d = step_wrap;
    end
  end

  // Run/idle control; a wrapping step ends a one-shot sweep.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (single & step & step_wrap & ~load_ok) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, index and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= KW'(1);
      gray_q  <= KW'(1);
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gray_q  <= gray_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = (state_q == RUN);
  assign sel_idx   = idx_q;
  assign sel_gray  = gray_q;
  assign wrap      = wrap_q;
  assign load_err  = err_q;

endmodule
